// File: rtl/spi_segment_display_ctrl.sv
// SPI mode-0 write slave feeding a multiplexed 7-segment scan engine.
// Holds the digit and control registers and drives the registered display outputs.
module spi_segment_display_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 10_000,
    parameter int BLINK_DIV  = 10_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_sck,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_done
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Stage p0: pin synchronisers, bit 2 is the delayed copy for edge detection
    logic [2:0] sck_p0;
    logic [2:0] cs_p0;
    logic [1:0] mosi_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_p0  <= 3'b000;
            cs_p0   <= 3'b111;
            mosi_p0 <= 2'b00;
        end else begin
            sck_p0  <= {sck_p0[1:0], spi_sck};
            cs_p0   <= {cs_p0[1:0], spi_cs_n};
            mosi_p0 <= {mosi_p0[0], spi_mosi};
        end
    end

    logic sck_rise, sck_fall, cs_low, cs_fall;
    assign sck_rise = sck_p0[1] & ~sck_p0[2];
    assign sck_fall = ~sck_p0[1] & sck_p0[2];
    assign cs_low   = ~cs_p0[1];
    assign cs_fall  = cs_low & cs_p0[2];

    // Stage p1: shift registers; vld_p1 marks the cycle after the 16th bit
    logic [4:0]  bit_cnt_p1;
    logic [15:0] rx_p1;
    logic [15:0] tx_p1;
    logic        vld_p1;
    logic [15:0] last_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_p1 <= 5'd0;
            rx_p1      <= 16'h0000;
            tx_p1      <= 16'h0000;
            vld_p1     <= 1'b0;
            spi_miso   <= 1'b0;
        end else begin
            vld_p1   <= 1'b0;
            spi_miso <= cs_low & tx_p1[15];
            if (cs_fall) begin
                bit_cnt_p1 <= 5'd0;
                tx_p1      <= last_word;
            end else if (cs_low) begin
                if (sck_rise && bit_cnt_p1 != 5'd16) begin
                    rx_p1      <= {rx_p1[14:0], mosi_p0[1]};
                    bit_cnt_p1 <= bit_cnt_p1 + 5'd1;
                    vld_p1     <= (bit_cnt_p1 == 5'd15);
                end
                if (sck_fall) begin
                    tx_p1 <= {tx_p1[14:0], 1'b0};
                end
            end
        end
    end

    // Stage p2: commit the frame into the register bank
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_en;
    logic [7:0] digit_q [NUM_DIGITS];
    logic [2:0] ctrl_q;

    assign wr_addr = rx_p1[11:8];
    assign wr_data = rx_p1[7:0];
    assign wr_en   = vld_p1 & rx_p1[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            last_word  <= 16'h0000;
            ctrl_q     <= 3'b001;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= 8'h00;
            end
        end else begin
            frame_done <= vld_p1;
            if (vld_p1) begin
                last_word <= rx_p1;
            end
            if (wr_en) begin
                if (int'(wr_addr) < NUM_DIGITS) begin
                    digit_q[wr_addr[IDX_W-1:0]] <= wr_data;
                end else if (wr_addr == 4'hF) begin
                    ctrl_q <= wr_data[2:0];
                end
            end
        end
    end

    // Free-running scan and blink timebases
    logic [SCAN_W-1:0]  scan_cnt;
    logic [IDX_W-1:0]   idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt    <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Stage p3: output select and registers
    logic [7:0]            cur_digit;
    logic [7:0]            seg_nxt;
    logic [NUM_DIGITS-1:0] en_nxt;
    logic                  disp_off;

    always_comb begin
        cur_digit = digit_q[idx];
        disp_off  = ctrl_q[2] | (ctrl_q[1] & blink_phase);
        seg_nxt   = ctrl_q[0] ? {cur_digit[7], hex7(cur_digit[3:0])} : cur_digit;
        en_nxt    = NUM_DIGITS'(1) << idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg      <= 8'h00;
            digit_en <= '0;
        end else begin
            seg      <= disp_off ? 8'h00 : seg_nxt;
            digit_en <= disp_off ? '0 : en_nxt;
        end
    end

endmodule

// File: tb/tb_spi_segment_display_ctrl.sv
// Directed bench for spi_segment_display_ctrl with a cycle-level display model.
// SPI pins are driven on falling clk edges; outputs are sampled 1 time unit later.
module tb_spi_segment_display_ctrl;

    localparam int ND = 4;
    localparam int SD = 16;
    localparam int BD = 600;
    localparam int H  = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spi_sck = 1'b0;
    logic          spi_cs_n = 1'b1;
    logic          spi_mosi = 1'b0;
    logic          spi_miso;
    logic [7:0]    seg;
    logic [ND-1:0] digit_en;
    logic          frame_done;

    always #5 clk = ~clk;

    spi_segment_display_ctrl #(
        .NUM_DIGITS(ND),
        .SCAN_DIV  (SD),
        .BLINK_DIV (BD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sck   (spi_sck),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .seg       (seg),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pend_cyc = 0;
    logic [15:0] pend_word = 16'h0000;
    logic [15:0] echo_exp = 16'h0000;

    logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    logic [7:0] m_digit [ND];
    logic [2:0] m_ctrl;

    // edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_seg(input logic [7:0] d, input logic [2:0] c, input bit ph);
        logic [7:0] t;
        t = hex_tab[d[3:0]];
        if (c[2] || (c[1] && ph)) return 8'h00;
        if (c[0]) return {d[7], t[6:0]};
        return d;
    endfunction

    // Output after edge k shows state held before edge k: k-1 counter ticks elapsed.
    initial begin
        int k, di, ph;
        logic [ND-1:0] exp_en;
        logic [7:0]    exp_seg;
        logic [3:0]    a;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n || cyc == 0) begin
                if (!rst_n) begin
                    for (int i = 0; i < ND; i++) m_digit[i] = 8'h00;
                    m_ctrl = 3'b001;
                    chk("rst_miso", {15'b0, spi_miso}, 16'h0);
                end
                chk("rst_seg", {8'b0, seg}, 16'h0);
                chk("rst_en", {12'b0, digit_en}, 16'h0);
                chk("rst_fd", {15'b0, frame_done}, 16'h0);
            end else begin
                k  = cyc;
                di = ((k - 1) / SD) % ND;
                ph = ((k - 1) / BD) % 2;
                exp_seg = model_seg(m_digit[di], m_ctrl, ph[0]);
                if (m_ctrl[2] || (m_ctrl[1] && ph == 1)) exp_en = '0;
                else exp_en = 4'(1) << di;
                chk("seg", {8'b0, seg}, {8'b0, exp_seg});
                chk("digit_en", {12'b0, digit_en}, {12'b0, exp_en});
                chk("frame_done", {15'b0, frame_done}, {15'b0, (pend_cyc == k)});
                if (pend_cyc == k && pend_word[15]) begin
                    a = pend_word[11:8];
                    if (int'(a) < ND) m_digit[a] = pend_word[7:0];
                    else if (a == 4'hF) m_ctrl = pend_word[2:0];
                end
            end
        end
    end

    task automatic spi_frame(input logic [15:0] w, input int nbits, output logic [15:0] got);
        got = 16'h0000;
        chk("miso_idle", {15'b0, spi_miso}, 16'h0);
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = w[15-i];
            repeat (H) @(negedge clk);
            got = {got[14:0], spi_miso};
            if (i == 15) begin
                pend_word = w;
                pend_cyc  = cyc + 4;
            end
            spi_sck = 1'b1;
            repeat (H) @(negedge clk);
            spi_sck = 1'b0;
        end
        repeat (H) @(negedge clk);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (6) @(negedge clk);
        if (nbits == 16) begin
            chk("miso_echo", got, echo_exp);
            echo_exp = w;
        end
    endtask

    task automatic wait_en(input logic [ND-1:0] want, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            #1;
            if (digit_en == want) hit = 1'b1;
        end
        chk("wait_en", {15'b0, hit}, 16'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] echo;
        int off_cnt;
        logic [ND-1:0] en_seq [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
        logic [7:0]    seg_seq [4] = '{8'h6D, 8'h77, 8'hF1, 8'h07};

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            spi_sck  = 1'($urandom_range(0, 1));
            spi_cs_n = 1'($urandom_range(0, 1));
            spi_mosi = 1'($urandom_range(0, 1));
        end
        spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("first_en", {12'b0, digit_en}, 16'h1);
        chk("first_seg", {8'b0, seg}, 16'h3F);

        spi_frame(16'h8005, 16, echo);
        spi_frame(16'h810A, 16, echo);
        spi_frame(16'h828F, 16, echo);
        spi_frame(16'h8307, 16, echo);
        chk("echo_828F", echo, 16'h828F);
        wait_en(4'h1, 4 * SD + 8);
        for (int d = 0; d < 5; d++) begin
            chk("scan_en", {12'b0, digit_en}, {12'b0, en_seq[d % 4]});
            chk("scan_seg", {8'b0, seg}, {8'b0, seg_seq[d % 4]});
            repeat (SD) @(negedge clk);
            #1;
        end

        spi_frame(16'h8F00, 16, echo);
        spi_frame(16'h8055, 16, echo);
        wait_en(4'h1, 4 * SD + 8);
        chk("raw_seg", {8'b0, seg}, 16'h55);

        spi_frame(16'h8012, 9, echo);
        spi_frame(16'h8F01, 16, echo);
        chk("abort_echo", echo, 16'h8055);
        wait_en(4'h1, 4 * SD + 8);
        chk("abort_digit0", {8'b0, seg}, 16'h6D);

        spi_frame(16'h8F03, 16, echo);
        off_cnt = 0;
        for (int i = 0; i < 2 * BD; i++) begin
            @(negedge clk); #1;
            if (digit_en == '0) off_cnt++;
        end
        chk("blink_off", 16'(off_cnt), 16'(BD));

        spi_frame(16'h8F05, 16, echo);
        repeat (7) @(negedge clk); #1;
        chk("blank_en", {12'b0, digit_en}, 16'h0);
        chk("blank_seg", {8'b0, seg}, 16'h0);

        spi_frame(16'h8F01, 16, echo);
        spi_frame(16'h8C33, 16, echo);
        spi_frame(16'h0003, 16, echo);
        chk("oor_echo", echo, 16'h8C33);
        spi_frame(16'h8F00, 16, echo);
        chk("nowr_echo", echo, 16'h0003);
        wait_en(4'h1, 4 * SD + 8);
        chk("raw_d0", {8'b0, seg}, 16'h55);
        wait_en(4'h4, 4 * SD + 8);
        chk("raw_d2", {8'b0, seg}, 16'h8F);

        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        spi_mosi = 1'b1;
        for (int i = 0; i < 5; i++) begin
            spi_sck = 1'b1; repeat (H) @(negedge clk);
            spi_sck = 1'b0; repeat (H) @(negedge clk);
        end
        rst_n = 1'b0;
        pend_cyc = 0;
        echo_exp = 16'h0000;
        repeat (3) @(negedge clk); #1;
        chk("midrst_en", {12'b0, digit_en}, 16'h0);
        chk("midrst_seg", {8'b0, seg}, 16'h0);
        spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rerst_en", {12'b0, digit_en}, 16'h1);
        chk("rerst_seg", {8'b0, seg}, 16'h3F);
        spi_frame(16'h8001, 16, echo);
        chk("rerst_echo", echo, 16'h0000);
        wait_en(4'h1, 4 * SD + 8);
        chk("rerst_d0", {8'b0, seg}, 16'h06);
        repeat (SD) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
